axi4_stream_pkt_fragmenter: RTL

AXI4_STREAM_PKT_FRAGMENTER -- requirements
Module: axi4_stream_pkt_fragmenter

---
 rtl/axi4_stream_pkt_fragmenter_if.sv | 35 +++
 rtl/axi4_stream_pkt_fragmenter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/axi4_stream_pkt_fragmenter_if.sv
// AXI4-Stream bundle shared by the fragmenter input and output.
//   tvalid/tready : beat handshake
//   tdata         : payload, byte lane i in tdata[8*i +: 8]
//   tstrb/tkeep   : per-byte qualifiers
//   tlast         : end of packet (input) or end of fragment (output)
//   tid/tdest     : routing sideband
//   tuser         : user sideband; bit 0 marks a fragment start on the output
interface axi4_stream_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned USER_WIDTH = 1
);
  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tstrb;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi4_stream_pkt_fragmenter.sv
// AXI4-Stream packet fragmenter. Cuts each input packet into fragments of at most S bytes
// (S sampled on the packet's first beat), each fragment realigned to byte lane 0. With
// fragmentation disabled the packet passes through unchanged and counts as one fragment.
//   clk_i           : clock, rising edge
//   rst_n_i         : synchronous active-low reset
//   frag_en_i       : 1 = fragment, 0 = pass-through (sampled per packet)
//   max_frag_size_i : fragment size in bytes; 0 or > MAX_FRAG_SIZE_B means MAX_FRAG_SIZE_B
//   pkt_i           : input packet stream
//   pkt_o           : output fragment stream, tuser[0] = first beat of fragment
//   frag_cnt_o      : number of fragments emitted, wraps at 2^16
module axi4_stream_pkt_fragmenter #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 1,
  parameter int unsigned DEST_WIDTH      = 1,
  parameter int unsigned USER_WIDTH      = 1,
  parameter int unsigned MAX_FRAG_SIZE_B = 2048,
  parameter int unsigned FRAG_SIZE_WIDTH = $clog2(MAX_FRAG_SIZE_B)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     frag_en_i,
  input  logic [FRAG_SIZE_WIDTH:0] max_frag_size_i,
  axi4_stream_if.slave             pkt_i,
  axi4_stream_if.master            pkt_o,
  output logic [15:0]              frag_cnt_o
);

  localparam int unsigned W    = DATA_WIDTH / 8;
  localparam int unsigned LvlW = $clog2(2 * W + 1);
  localparam int unsigned SzW  = FRAG_SIZE_WIDTH + 1;
  localparam int unsigned CntW = (LvlW > SzW) ? LvlW + 1 : SzW + 1;
  localparam logic [SzW-1:0] MaxSize = SzW'(MAX_FRAG_SIZE_B);

  // Two-word byte buffer; byte 0 of buf_q is always the next byte to leave.
  logic [2*DATA_WIDTH-1:0] buf_q, buf_d, buf_shift;
  logic [LvlW-1:0]         lvl_q, lvl_d;
  logic [SzW-1:0]          rem_q, rem_d;     // bytes left in the current fragment
  logic [SzW-1:0]          size_q, size_d;   // effective fragment size of this packet
  logic                    pass_q, pass_d;
  logic                    last_in_buf_q, last_in_buf_d;  // packet tail is in the buffer
  logic                    in_first_q, in_first_d;        // next input beat starts a packet
  logic                    frag_first_q, frag_first_d;    // next output beat starts a fragment
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [DEST_WIDTH-1:0]   dest_q, dest_d;
  logic [USER_WIDTH-1:0]   user_q, user_d;
  logic [15:0]             cnt_q, cnt_d;

  logic [CntW-1:0]         lvl_c, rem_c, n_c, lvl_after, in_bytes;
  logic                    out_valid, out_acc, pkt_end, frag_end;
  logic                    in_ready, in_acc, start;
  logic [SzW-1:0]          sz_eff;
  logic [W-1:0]            out_keep;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [USER_WIDTH-1:0]   user_cap;

  always_comb begin
    lvl_c = CntW'(lvl_q);
    rem_c = CntW'(rem_q);

    // Bytes the pending output beat carries: bounded by the bus, the buffer and the fragment.
    n_c = CntW'(W);
    if (lvl_c < n_c) n_c = lvl_c;
    if (!pass_q && rem_c < n_c) n_c = rem_c;

    pkt_end   = last_in_buf_q && (n_c == lvl_c);
    frag_end  = pkt_end || (!pass_q && (n_c == rem_c));
    out_valid = rst_n_i && (lvl_q != '0) &&
                ((lvl_c >= CntW'(W)) || (!pass_q && (lvl_c >= rem_c)) || last_in_buf_q);
    out_acc   = out_valid && pkt_o.tready;
    lvl_after = out_acc ? (lvl_c - n_c) : lvl_c;

    // Once a packet's tail is buffered, the next packet waits for its final output beat.
    in_ready = rst_n_i && (lvl_after <= CntW'(W)) && (!last_in_buf_q || (out_acc && pkt_end));
    in_acc   = in_ready && pkt_i.tvalid;
    start    = in_acc && in_first_q;

    in_bytes = '0;
    for (int i = 0; i < W; i++) begin
      in_bytes = in_bytes + CntW'(pkt_i.tkeep[i]);
    end

    sz_eff = max_frag_size_i;
    if ((sz_eff == '0) || (sz_eff > MaxSize)) sz_eff = MaxSize;

    for (int i = 0; i < W; i++) begin
      out_keep[i]        = (CntW'(i) < n_c);
      out_data[8*i +: 8] = out_keep[i] ? buf_q[8*i +: 8] : 8'h00;
    end

    // Drop the bytes leaving this cycle, then append the new beat right after what remains.
    buf_shift = out_acc ? (buf_q >> {n_c, 3'b000}) : buf_q;
    buf_d     = buf_shift;
    if (in_acc) begin
      for (int i = 0; i < W; i++) begin
        if (pkt_i.tkeep[i] && ((int'(lvl_after) + i) < 2 * W)) begin
          buf_d[(int'(lvl_after) + i) * 8 +: 8] = pkt_i.tdata[8*i +: 8];
        end
      end
    end
    lvl_d = LvlW'(lvl_after + (in_acc ? in_bytes : '0));

    rem_d = rem_q;
    if (start) begin
      rem_d = sz_eff;
    end else if (out_acc) begin
      rem_d = frag_end ? size_q : (rem_q - SzW'(n_c));
    end

    user_cap    = pkt_i.tuser;
    user_cap[0] = 1'b0;

    size_d = start ? sz_eff : size_q;
    pass_d = start ? !frag_en_i : pass_q;
    id_d   = start ? pkt_i.tid : id_q;
    dest_d = start ? pkt_i.tdest : dest_q;
    user_d = start ? user_cap : user_q;

    in_first_d    = in_acc ? pkt_i.tlast : in_first_q;
    last_in_buf_d = (last_in_buf_q && !(out_acc && pkt_end)) || (in_acc && pkt_i.tlast);
    frag_first_d  = out_acc ? frag_end : frag_first_q;
    cnt_d         = cnt_q + 16'(out_acc && frag_end);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      buf_q         <= '0;
      lvl_q         <= '0;
      rem_q         <= '0;
      size_q        <= '0;
      pass_q        <= 1'b0;
      last_in_buf_q <= 1'b0;
      in_first_q    <= 1'b1;
      frag_first_q  <= 1'b1;
      id_q          <= '0;
      dest_q        <= '0;
      user_q        <= '0;
      cnt_q         <= '0;
    end else begin
      buf_q         <= buf_d;
      lvl_q         <= lvl_d;
      rem_q         <= rem_d;
      size_q        <= size_d;
      pass_q        <= pass_d;
      last_in_buf_q <= last_in_buf_d;
      in_first_q    <= in_first_d;
      frag_first_q  <= frag_first_d;
      id_q          <= id_d;
      dest_q        <= dest_d;
      user_q        <= user_d;
      cnt_q         <= cnt_d;
    end
  end

  assign pkt_o.tvalid = out_valid;
  assign pkt_o.tdata  = out_data;
  assign pkt_o.tkeep  = out_keep;
  assign pkt_o.tstrb  = out_keep;
  assign pkt_o.tlast  = frag_end;
  assign pkt_o.tid    = id_q;
  assign pkt_o.tdest  = dest_q;
  assign pkt_o.tuser  = user_q | USER_WIDTH'(frag_first_q);
  assign pkt_i.tready = in_ready;
  assign frag_cnt_o   = cnt_q;

endmodule
